// File: rtl/jtag_axi_sram_slave.sv
// jtag_axi_sram_slave: AXI4 responder into a byte-strobed SRAM with independent write/read FSMs.
// Optional stall input is enabled by defining JTAG_AXI_SLV_STALL_EN.
package jtag_axi_pkg;
  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;
  localparam int AXI_IDW = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef struct packed {
    logic [AXI_IDW-1:0] awid;
    logic [AXI_AW-1:0]  awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic               awvalid;
    logic [AXI_DW-1:0]  wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               bready;
    logic [AXI_IDW-1:0] arid;
    logic [AXI_AW-1:0]  araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic               arvalid;
    logic               rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic               awready;
    logic               wready;
    logic [AXI_IDW-1:0] bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               arready;
    logic [AXI_IDW-1:0] rid;
    logic [AXI_DW-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
  } s_axi_miso_t;
endpackage

module jtag_axi_sram_slave import jtag_axi_pkg::*; #(
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter int MEM_WORDS = 1024,
  parameter int RESP_LAT = 0
) (
  input  logic        clk,
  input  logic        aresn,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o,
  output logic        err_o
`ifdef JTAG_AXI_SLV_STALL_EN
  , input logic       stall_i
`endif
);
  localparam int NB = AXI_DW / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int AW1 = AXI_AW + 1;
  localparam logic [AXI_AW:0] SPAN = AW1'(MEM_WORDS * NB);
  typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_DRAIN, W_LAT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} r_state_t;
  localparam w_state_t W_POST = (RESP_LAT == 0) ? W_RESP : W_LAT;
  localparam r_state_t R_POST = (RESP_LAT == 0) ? R_RESP : R_LAT;

  function automatic logic [1:0] f_decode(input logic [AXI_AW-1:0] a, input logic [2:0] sz, input logic burst);
    logic [AXI_AW:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (off >= SPAN) ? RESP_DECERR : (sz > 3'(ADDR_LSB) || burst) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  logic w_stall;
`ifdef JTAG_AXI_SLV_STALL_EN
  assign w_stall = stall_i;
`else
  assign w_stall = 1'b0;
`endif

  logic [AXI_DW-1:0] r_mem [MEM_WORDS];
  logic r_live, r_err;
  w_state_t r_ws, w_ws_nxt;
  r_state_t r_rs, w_rs_nxt;
  logic [3:0] r_wcnt, r_rlat;
  logic [AXI_IDW-1:0] r_awid, r_bid, r_rid, w_id;
  logic [AXI_AW-1:0] r_awaddr, w_addr;
  logic [7:0] r_awlen, w_len, r_rcnt;
  logic [2:0] r_awsize, w_size;
  logic [AXI_DW-1:0] r_wdata, w_wdata, r_rdata;
  logic [NB-1:0] r_wstrb, w_wstrb;
  logic r_wlast, w_last;
  logic [1:0] r_bresp, r_rresp, w_wresp, w_rdec;
  logic [IW-1:0] w_widx, r_ridx, w_ridx;
  logic w_awready, w_wready, w_arready, w_aw_hs, w_w_hs, w_ar_hs, w_both;
  logic w_b_hs, w_r_hs, w_rlast, w_r_enter;

  assign w_awready = r_live && !w_stall && (r_ws == W_IDLE || r_ws == W_WAIT_AW);
  assign w_wready  = r_live && !w_stall && (r_ws == W_IDLE || r_ws == W_WAIT_W || r_ws == W_DRAIN);
  assign w_arready = r_live && !w_stall && r_rs == R_IDLE;
  assign w_aw_hs = axi_mosi_i.awvalid && w_awready;
  assign w_w_hs  = axi_mosi_i.wvalid && w_wready;
  assign w_ar_hs = axi_mosi_i.arvalid && w_arready;
  assign w_b_hs  = r_ws == W_RESP && axi_mosi_i.bready;
  assign w_rlast = r_rs == R_RESP && r_rcnt == 8'd0;
  assign w_r_hs  = r_rs == R_RESP && axi_mosi_i.rready;
  assign w_both = (r_ws == W_IDLE && w_aw_hs && w_w_hs) || (r_ws == W_WAIT_W && w_w_hs) || (r_ws == W_WAIT_AW && w_aw_hs);
  assign w_id    = (r_ws == W_WAIT_W) ? r_awid : axi_mosi_i.awid;
  assign w_addr  = (r_ws == W_WAIT_W) ? r_awaddr : axi_mosi_i.awaddr;
  assign w_len   = (r_ws == W_WAIT_W) ? r_awlen : axi_mosi_i.awlen;
  assign w_size  = (r_ws == W_WAIT_W) ? r_awsize : axi_mosi_i.awsize;
  assign w_wdata = (r_ws == W_WAIT_AW) ? r_wdata : axi_mosi_i.wdata;
  assign w_wstrb = (r_ws == W_WAIT_AW) ? r_wstrb : axi_mosi_i.wstrb;
  assign w_last  = (r_ws == W_WAIT_AW) ? r_wlast : axi_mosi_i.wlast;
  assign w_wresp = f_decode(w_addr, w_size, w_len != 8'd0);
  assign w_widx  = w_addr[ADDR_LSB +: IW];
  assign w_ridx  = (r_rs == R_IDLE) ? axi_mosi_i.araddr[ADDR_LSB +: IW] : r_ridx;
  // Burst reads decode the first beat on address/size only; later beats are forced to SLVERR.
  assign w_rdec  = (r_rs == R_IDLE) ? f_decode(axi_mosi_i.araddr, axi_mosi_i.arsize, 1'b0) : r_rresp;
  assign w_r_enter = w_rs_nxt == R_RESP && r_rs != R_RESP;

  // Write next state: completing AW+W commits, optional burst drain, latency, then B.
  always_comb begin
    w_ws_nxt = r_ws;
    if (w_both) w_ws_nxt = (w_len != 8'd0 && !w_last) ? W_DRAIN : W_POST;
    else if (r_ws == W_IDLE && w_aw_hs) w_ws_nxt = W_WAIT_W;
    else if (r_ws == W_IDLE && w_w_hs) w_ws_nxt = W_WAIT_AW;
    else if (r_ws == W_DRAIN && w_w_hs && axi_mosi_i.wlast) w_ws_nxt = W_POST;
    else if (r_ws == W_LAT && !w_stall && r_wcnt == 4'(RESP_LAT - 1)) w_ws_nxt = W_RESP;
    else if (w_b_hs) w_ws_nxt = W_IDLE;
  end

  // Read next state: capture AR, wait latency, stream len+1 beats.
  always_comb begin
    w_rs_nxt = r_rs;
    if (w_ar_hs) w_rs_nxt = R_POST;
    else if (r_rs == R_LAT && !w_stall && r_rlat == 4'(RESP_LAT - 1)) w_rs_nxt = R_RESP;
    else if (w_r_hs && w_rlast) w_rs_nxt = R_IDLE;
  end

  // Write channel state, captured request fields and B response.
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) begin
      r_live <= 1'b0;
      r_ws <= W_IDLE;
      r_wcnt <= '0;
      r_awid <= '0;
      r_awaddr <= '0;
      r_awlen <= '0;
      r_awsize <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wlast <= 1'b0;
      r_bid <= '0;
      r_bresp <= RESP_OKAY;
    end else begin
      r_live <= 1'b1;
      r_ws <= w_ws_nxt;
      r_wcnt <= (r_ws != W_LAT) ? 4'd0 : w_stall ? r_wcnt : r_wcnt + 4'd1;
      if (w_aw_hs) begin
        r_awid <= axi_mosi_i.awid;
        r_awaddr <= axi_mosi_i.awaddr;
        r_awlen <= axi_mosi_i.awlen;
        r_awsize <= axi_mosi_i.awsize;
      end
      if (w_w_hs) begin
        r_wdata <= axi_mosi_i.wdata;
        r_wstrb <= axi_mosi_i.wstrb;
        r_wlast <= axi_mosi_i.wlast;
      end
      if (w_both) begin
        r_bid <= w_id;
        r_bresp <= w_wresp;
      end
    end
  end

  // Array commit, byte-strobed, on the edge where both AW and W are held.
  always_ff @(posedge clk) begin
    if (w_both && w_wresp == RESP_OKAY)
      for (int b = 0; b < NB; b++)
        if (w_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
  end

  // Read channel state; rdata sampled from pre-edge array contents when entering R_RESP.
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) begin
      r_rs <= R_IDLE;
      r_rlat <= '0;
      r_rcnt <= '0;
      r_rid <= '0;
      r_ridx <= '0;
      r_rresp <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      r_rs <= w_rs_nxt;
      r_rlat <= (r_rs != R_LAT) ? 4'd0 : w_stall ? r_rlat : r_rlat + 4'd1;
      if (w_ar_hs) begin
        r_rid <= axi_mosi_i.arid;
        r_ridx <= w_ridx;
        r_rcnt <= axi_mosi_i.arlen;
        r_rresp <= w_rdec;
      end
      if (w_r_enter) r_rdata <= (w_rdec == RESP_OKAY) ? r_mem[w_ridx] : '0;
      if (w_r_hs && !w_rlast) begin
        r_rcnt <= r_rcnt - 8'd1;
        r_rresp <= RESP_SLVERR;
        r_rdata <= '0;
      end
    end
  end

  // Error pulse follows any non-OKAY B or R handshake.
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) r_err <= 1'b0;
    else r_err <= (w_b_hs && r_bresp != RESP_OKAY) || (w_r_hs && r_rresp != RESP_OKAY);
  end

  // Output channel assembly.
  always_comb begin
    axi_miso_o = '0;
    axi_miso_o.awready = w_awready;
    axi_miso_o.wready = w_wready;
    axi_miso_o.bid = r_bid;
    axi_miso_o.bresp = r_bresp;
    axi_miso_o.bvalid = r_ws == W_RESP;
    axi_miso_o.arready = w_arready;
    axi_miso_o.rid = r_rid;
    axi_miso_o.rdata = r_rdata;
    axi_miso_o.rresp = r_rresp;
    axi_miso_o.rlast = w_rlast;
    axi_miso_o.rvalid = r_rs == R_RESP;
  end

  assign err_o = r_err;
endmodule
